// File: rtl/m_stage.sv
// m_stage: Y86-64 pipeline Memory stage.
// Holds the byte-addressed data memory (8-byte little-endian accesses) and
// produces m_valM / m_stat for the W register, plus read/write counters.
// Optional build macro MEM_LATENCY_EN adds a wait-state FSM that stalls the
// pipeline for WAIT_CYCLES cycles on every valid access; without it the stall
// output is tied low and every access completes in the cycle it is presented.
//
// Handshake: m_stall is a hold request to pipeline control. While it is high,
// M inputs are held stable by the pipeline and nothing in this block commits;
// the access commits at the first posedge where m_stall is low.
`timescale 1ns/1ps
module m_stage #(
    parameter int unsigned MEM_BYTES   = 8192,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_stat,
    input  logic [63:0] M_valA,
    input  logic [63:0] M_valE,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat,
    output logic        m_stall,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int AW = $clog2(MEM_BYTES);

    // Reject configurations the address math cannot support.
    if (MEM_BYTES < 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0 || WAIT_CYCLES > 15) begin : g_bad_cfg
        $error("m_stage: illegal MEM_BYTES / WAIT_CYCLES");
    end

    logic [7:0]    mem [MEM_BYTES];

    logic          is_rd;
    logic          is_wr;
    logic [63:0]   addr;
    logic [AW-1:0] idx;
    logic          dmem_error;
    logic          access_ok;
    logic          commit;
    logic          wr_en;
    logic [31:0]   rd_count_q, rd_count_d;
    logic [31:0]   wr_count_q, wr_count_d;

    // Decode the access type, pick the address and check the bounds.
    always_comb begin
        is_rd      = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
        is_wr      = (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
        addr       = ((M_icode == 4'h9) || (M_icode == 4'hB)) ? M_valA : M_valE;
        idx        = addr[AW-1:0];
        // Unsigned 64-bit compare: huge addresses never wrap into range.
        dmem_error = (is_rd || is_wr) && (addr > 64'(MEM_BYTES - 8));
        access_ok  = (is_rd || is_wr) && !dmem_error && (M_stat == 4'h1);
        m_stat     = dmem_error ? 4'h3 : M_stat;
    end

    // Combinational 8-byte little-endian read; zero when not a legal read.
    always_comb begin
        m_valM = '0;
        if (is_rd && !dmem_error) begin
            for (int k = 0; k < 8; k++) begin
                m_valM[8*k +: 8] = mem[idx + AW'(k)];
            end
        end
    end

`ifdef MEM_LATENCY_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;

    // Stall while a new access is seen in IDLE and throughout WAIT; commit in DONE.
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            m_stall = 1'b0;
            commit  = access_ok;
        end else begin
            m_stall = !rst && (((state_q == S_IDLE) && access_ok) || (state_q == S_WAIT));
            commit  = (state_q == S_DONE) && access_ok;
        end
    end

    // Wait-state sequencer. The IDLE cycle that first sees the access is the
    // first stall cycle, so cnt holds the number of WAIT cycles still to go
    // after the current one; this gives exactly WAIT_CYCLES stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access_ok && (WAIT_CYCLES != 0)) begin
                        if (WAIT_CYCLES == 1) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
`else
    // No wait states: a valid access commits in the cycle it is presented.
    always_comb begin
        m_stall = 1'b0;
        commit  = access_ok;
    end
`endif

    // Next-state for the access counters and the memory write enable.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (commit && is_rd) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (commit && is_wr) begin
            wr_count_d = wr_count_q + 32'd1;
        end
        wr_en = commit && is_wr && !rst;
    end

    // Access counters, cleared by reset and wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Memory write port; contents are intentionally not touched by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem[idx + AW'(k)] <= M_valA[8*k +: 8];
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_m_stage.sv
// tb_m_stage: randomized bench for m_stage with a byte-array memory model.
// Works for the default build and for the MEM_LATENCY_EN build.
`timescale 1ns/1ps
module tb_m_stage;

    localparam int unsigned MEM_BYTES   = 8192;
    localparam int unsigned WAIT_CYCLES = 2;
`ifdef MEM_LATENCY_EN
    localparam bit LAT = 1'b1;
`else
    localparam bit LAT = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  M_icode;
    logic [3:0]  M_stat;
    logic [63:0] M_valA;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_stat;
    logic        m_stall;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    always #5 clk = ~clk;

    m_stage #(.MEM_BYTES(MEM_BYTES), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .M_icode  (M_icode),
        .M_stat   (M_stat),
        .M_valA   (M_valA),
        .M_valE   (M_valE),
        .m_valM   (m_valM),
        .m_stat   (m_stat),
        .m_stall  (m_stall),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    // ---------------- reference model ----------------
    logic [7:0]  mdl_mem   [MEM_BYTES];
    bit          mdl_known [MEM_BYTES];
    int unsigned mdl_rd_cnt;
    int unsigned mdl_wr_cnt;
    logic        exp_stall;
    bit          chk_en;

    int          n_checks;
    int          n_fail;
    logic [63:0] valm_seen;
    logic [3:0]  stat_seen;
    int          stall_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mdl_is_rd();
        return (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
    endfunction

    function automatic bit mdl_is_wr();
        return (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
    endfunction

    function automatic logic [63:0] mdl_addr();
        if ((M_icode == 4'h9) || (M_icode == 4'hB)) return M_valA;
        return M_valE;
    endfunction

    // Any byte of the 8-byte window past the end of memory is an address error.
    function automatic bit mdl_err();
        logic [63:0] last_ok;
        last_ok = 64'(MEM_BYTES) - 64'd8;
        return (mdl_is_rd() || mdl_is_wr()) && (mdl_addr() > last_ok);
    endfunction

    function automatic bit mdl_valid();
        return (mdl_is_rd() || mdl_is_wr()) && !mdl_err() && (M_stat == 4'h1);
    endfunction

    function automatic int mdl_base();
        return int'(mdl_addr() & 64'(MEM_BYTES - 1));
    endfunction

    function automatic bit mdl_readable();
        int b;
        if (!mdl_is_rd() || mdl_err()) return 1'b1;
        b = mdl_base();
        for (int k = 0; k < 8; k++) begin
            if (!mdl_known[b + k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] mdl_valm();
        logic [63:0] v;
        int b;
        v = 64'd0;
        if (!mdl_is_rd() || mdl_err()) return v;
        b = mdl_base();
        for (int k = 0; k < 8; k++) begin
            v = v | (64'(mdl_mem[b + k]) << (8 * k));
        end
        return v;
    endfunction

    task automatic mdl_commit();
        int b;
        logic [63:0] d;
        b = mdl_base();
        d = M_valA;
        if (mdl_is_wr()) begin
            for (int k = 0; k < 8; k++) begin
                mdl_mem[b + k]   = d[7:0];
                mdl_known[b + k] = 1'b1;
                d = d >> 8;
            end
            mdl_wr_cnt++;
        end
        if (mdl_is_rd()) mdl_rd_cnt++;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_stat", 64'(m_stat), 64'(mdl_err() ? 4'h3 : M_stat));
            if (mdl_readable()) check("m_valM", m_valM, mdl_valm());
            check("m_stall", 64'(m_stall), 64'(exp_stall));
            check("rd_count", 64'(rd_count), 64'(mdl_rd_cnt));
            check("wr_count", 64'(wr_count), 64'(mdl_wr_cnt));
        end
    end

    // ---------------- driver ----------------
    // Called just after a posedge; returns just after the edge that retires
    // the instruction. Inputs stay stable for the whole stall window.
    task automatic issue(input logic [3:0] ic, input logic [3:0] st,
                         input logic [63:0] a, input logic [63:0] e);
        int n;
        M_icode = ic;
        M_stat  = st;
        M_valA  = a;
        M_valE  = e;
        n = (LAT && mdl_valid()) ? int'(WAIT_CYCLES) : 0;
        stall_seen = 0;
        for (int c = 0; c < n; c++) begin
            exp_stall = 1'b1;
            @(negedge clk);
            if (m_stall) stall_seen++;
            @(posedge clk);
            #1;
        end
        exp_stall = 1'b0;
        @(negedge clk);
        valm_seen = m_valM;
        stat_seen = m_stat;
        @(posedge clk);
        if (mdl_valid()) mdl_commit();
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] icode_tbl [12];

    initial begin
        logic [63:0] a, e, ad, dat;
        logic [3:0]  ic, st;
        int          r;

        icode_tbl = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5, 4'h1, 4'h0, 4'h2, 4'h6};
        n_checks   = 0;
        n_fail     = 0;
        mdl_rd_cnt = 0;
        mdl_wr_cnt = 0;
        exp_stall  = 1'b0;
        chk_en     = 1'b0;
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            mdl_known[i] = 1'b0;
            mdl_mem[i]   = 8'h00;
        end
        rst     = 1'b1;
        M_icode = 4'h1;
        M_stat  = 4'h1;
        M_valA  = '0;
        M_valE  = '0;

        // Reset state
        #1;
        check("reset_stall", 64'(m_stall), 64'd0);
        check("reset_rd_count", 64'(rd_count), 64'd0);
        check("reset_wr_count", 64'(wr_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // rmmovq store, byte order
        issue(4'h4, 4'h1, 64'h1122334455667788, 64'h100);
        check("t1_wr_count", 64'(wr_count), 64'd1);
        check("t1_model_lo", 64'(mdl_mem[32'h100]), 64'h88);
        check("t1_model_hi", 64'(mdl_mem[32'h107]), 64'h11);
        if (LAT) check("t5_stall_cycles", 64'(stall_seen), 64'd2);

        // mrmovq read back
        issue(4'h5, 4'h1, 64'h0, 64'h100);
        check("t2_valM", valm_seen, 64'h1122334455667788);
        check("t2_stat", 64'(stat_seen), 64'd1);
        check("t2_rd_count", 64'(rd_count), 64'd1);
        if (LAT) check("t5_restall_cycles", 64'(stall_seen), 64'd2);

        // Bounds
        issue(4'h5, 4'h1, 64'h0, 64'(MEM_BYTES - 7));
        check("t3_rd_oob_stat", 64'(stat_seen), 64'd3);
        check("t3_rd_oob_valM", valm_seen, 64'd0);
        issue(4'h4, 4'h1, 64'hDEAD, 64'hFFFFFFFFFFFFFFFC);
        check("t3_wr_oob_stat", 64'(stat_seen), 64'd3);
        check("t3_wr_oob_count", 64'(wr_count), 64'd1);
        issue(4'h4, 4'h1, 64'hA5A5_0000_1234_5678, 64'(MEM_BYTES - 8));
        issue(4'h5, 4'h1, 64'h0, 64'(MEM_BYTES - 8));
        check("t3_edge_stat", 64'(stat_seen), 64'd1);
        check("t3_edge_valM", valm_seen, 64'hA5A5_0000_1234_5678);

        // popq/ret address from valA; bubble
        issue(4'h4, 4'h1, 64'h0BAD_0BAD_0BAD_0BAD, 64'h108);
        issue(4'hB, 4'h1, 64'h100, 64'h108);
        check("t4_pop_valM", valm_seen, 64'h1122334455667788);
        issue(4'h1, 4'h2, 64'h100, 64'h100);
        check("t4_bubble_valM", valm_seen, 64'd0);
        check("t4_bubble_stat", 64'(stat_seen), 64'd2);
        check("t4_bubble_stall", 64'(stall_seen), 64'd0);
        // Non-AOK store must not land
        issue(4'h4, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100);
        issue(4'h5, 4'h1, 64'h0, 64'h100);
        check("t4_nonaok_nowrite", valm_seen, 64'h1122334455667788);

`ifdef MEM_LATENCY_EN
        // Reset during WAIT drops the pending store and clears counters
        issue(4'h4, 4'h1, 64'h0102030405060708, 64'h300);
        M_icode   = 4'h4;
        M_stat    = 4'h1;
        M_valA    = 64'hCAFE_F00D_CAFE_F00D;
        M_valE    = 64'h300;
        exp_stall = 1'b1;
        @(posedge clk);
        #1;
        check("t6_stall_in_wait", 64'(m_stall), 64'd1);
        rst        = 1'b1;
        mdl_rd_cnt = 0;
        mdl_wr_cnt = 0;
        exp_stall  = 1'b0;
        #1;
        check("t6_stall_on_rst", 64'(m_stall), 64'd0);
        check("t6_wr_count_rst", 64'(wr_count), 64'd0);
        check("t6_rd_count_rst", 64'(rd_count), 64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        M_icode = 4'h1;
        issue(4'h5, 4'h1, 64'h0, 64'h300);
        check("t6_target_unchanged", valm_seen, 64'h0102030405060708);
`endif

        // Prefill a small window so random reads hit known bytes
        for (int k = 0; k < 9; k++) begin
            issue(4'h4, 4'h1, {$urandom, $urandom}, 64'h200 + 64'(8 * k));
        end

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            ic = icode_tbl[$urandom_range(0, 11)];
            st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            r  = $urandom_range(0, 9);
            if (r <= 6)      ad = 64'h200 + 64'($urandom_range(0, 64));
            else if (r == 7) ad = 64'(MEM_BYTES - 8);
            else if (r == 8) ad = 64'(MEM_BYTES - 8) + 64'($urandom_range(1, 7));
            else             ad = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            dat = {$urandom, $urandom};
            if ((ic == 4'h9) || (ic == 4'hB)) begin
                a = ad;
                e = {$urandom, $urandom};
            end else begin
                a = dat;
                e = ad;
            end
            issue(ic, st, a, e);
        end

        M_icode = 4'h1;
        M_stat  = 4'h1;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
